// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/double-click/long/repeat
// events, timed in milliseconds from an internal prescaler.
module button_event_decoder #(
  parameter int unsigned CLOCK     = 27_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DOUBLE_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic       i_clk,
  input  logic       resetn,
  input  logic       i_db,
  input  logic       i_en,
  output logic       o_press,
  output logic       o_release,
  output logic       o_click,
  output logic       o_dclick,
  output logic       o_long,
  output logic       o_repeat,
  output logic       o_held,
  output logic [2:0] o_state
);

  localparam int unsigned ClkPerMs = CLOCK / 1000;
  localparam int unsigned PrescW   = (ClkPerMs > 1) ? $clog2(ClkPerMs) : 1;
  localparam int unsigned MaxLd    = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int unsigned MaxMs    = (MaxLd > REPEAT_MS) ? MaxLd : REPEAT_MS;
  localparam int unsigned MsW      = $clog2(MaxMs + 1);

  localparam logic [PrescW-1:0] PrescLast  = PrescW'(ClkPerMs - 1);
  localparam logic [MsW-1:0]    LongLast   = MsW'(LONG_MS - 1);
  localparam logic [MsW-1:0]    DoubleLast = MsW'((DOUBLE_MS == 0) ? 0 : DOUBLE_MS - 1);
  localparam logic [MsW-1:0]    RepeatLast = MsW'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDown1  = 3'd1,
    StUp1    = 3'd2,
    StLong   = 3'd3,
    StWaitUp = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              db_q;
  logic              armed_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [MsW-1:0]    ms_q, ms_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic click_q, click_d;
  logic dclick_q, dclick_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic held_q;

  logic rise, fall;
  logic tick, long_exp, dbl_exp, rep_exp;
  logic tclr, timer_run;

  // A rise only counts once the button has been seen released since reset, so a button held
  // through reset cannot generate a press.
  assign rise = i_db & ~db_q & armed_q;
  assign fall = ~i_db & db_q;

  // Expiry lands exactly N*ClkPerMs edges after the clearing edge.
  assign tick     = (presc_q == PrescLast);
  assign long_exp = tick && (ms_q == LongLast);
  assign dbl_exp  = (DOUBLE_MS != 0) && tick && (ms_q == DoubleLast);
  assign rep_exp  = (REPEAT_MS != 0) && tick && (ms_q == RepeatLast);

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    tclr      = 1'b0;

    if (!i_en) begin
      state_d = StIdle;
      tclr    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StDown1;
            press_d = 1'b1;
          end
        end
        StDown1: begin
          if (fall) begin
            release_d = 1'b1;
            if (DOUBLE_MS == 0) begin
              state_d = StIdle;
              click_d = 1'b1;
            end else begin
              state_d = StUp1;
            end
          end else if (long_exp) begin
            state_d = StLong;
            long_d  = 1'b1;
          end
        end
        StUp1: begin
          if (rise) begin
            state_d  = StWaitUp;
            press_d  = 1'b1;
            dclick_d = 1'b1;
          end else if (dbl_exp) begin
            state_d = StIdle;
            click_d = 1'b1;
          end
        end
        StLong: begin
          if (fall) begin
            state_d   = StIdle;
            release_d = 1'b1;
          end else if (rep_exp) begin
            repeat_d = 1'b1;
            tclr     = 1'b1;
          end
        end
        StWaitUp: begin
          if (fall) begin
            state_d   = StIdle;
            release_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q) begin
      tclr = 1'b1;
    end

    // Idle-type states keep the timer parked at zero so it can never wrap.
    timer_run = (state_q == StDown1) || (state_q == StUp1) ||
                ((state_q == StLong) && (REPEAT_MS != 0));

    presc_d = presc_q;
    ms_d    = ms_q;
    if (tclr || !timer_run) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = ms_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      db_q      <= 1'b0;
      armed_q   <= 1'b0;
      presc_q   <= '0;
      ms_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_q      <= i_db;
      armed_q   <= armed_q | ~i_db;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= (state_d == StLong);
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_dclick  = dclick_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: table of directed segments, hand-written reset/enable
// sequences, and random button activity checked every cycle against a timestamp-based model.
module tb_button_event_decoder;

  localparam int unsigned Clock    = 4000;
  localparam int unsigned LongMs   = 10;
  localparam int unsigned DoubleMs = 5;
  localparam int unsigned RepeatMs = 3;

  localparam int ClkMs     = Clock / 1000;
  localparam int LongClk   = LongMs * ClkMs;
  localparam int DoubleClk = DoubleMs * ClkMs;
  localparam int RepeatClk = RepeatMs * ClkMs;

  // Pulse field order: press, release, click, dclick, long, repeat.
  localparam logic [5:0] EvNone  = 6'b000000;
  localparam logic [5:0] EvPress = 6'b100000;
  localparam logic [5:0] EvRel   = 6'b010000;
  localparam logic [5:0] EvClick = 6'b001000;
  localparam logic [5:0] EvDclk  = 6'b000100;
  localparam logic [5:0] EvLong  = 6'b000010;
  localparam logic [5:0] EvRep   = 6'b000001;

  logic       i_clk = 1'b0;
  logic       resetn, i_db, i_en;
  logic       o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held;
  logic [2:0] o_state;
  logic [9:0] dut_vec;

  button_event_decoder #(
    .CLOCK    (Clock),
    .LONG_MS  (LongMs),
    .DOUBLE_MS(DoubleMs),
    .REPEAT_MS(RepeatMs)
  ) dut (
    .i_clk    (i_clk),
    .resetn   (resetn),
    .i_db     (i_db),
    .i_en     (i_en),
    .o_press  (o_press),
    .o_release(o_release),
    .o_click  (o_click),
    .o_dclick (o_dclick),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_held   (o_held),
    .o_state  (o_state)
  );

  always #5 i_clk = ~i_clk;

  assign dut_vec = {o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held, o_state};

  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  string tag     = "init";

  // Reference model: button phase plus the edge index at which the current timing interval began.
  int         m_mode;
  int         m_mark;
  bit         m_dbq;
  bit         m_armed;
  logic [9:0] m_exp;

  typedef struct {
    string      name;
    logic       db;
    logic       en;
    int         n;
    logic [5:0] pul;
    logic [2:0] st;
  } seg_t;

  seg_t tbl[$];

  function automatic logic [9:0] ev(input logic [5:0] pul, input logic [2:0] st);
    return {pul, (st == 3'd3), st};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b required %b (p,r,c,d,l,rp,held,state)",
                  name, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_dbq   = 1'b0;
    m_armed = 1'b0;
    m_mark  = cyc;
    m_exp   = '0;
  endtask

  task automatic model_edge(input logic db, input logic en);
    bit         rise, fall, rep;
    int         el, nxt;
    logic [5:0] pul;
    rise = db && !m_dbq && m_armed;
    fall = !db && m_dbq;
    el   = cyc - m_mark;
    nxt  = m_mode;
    pul  = EvNone;
    rep  = 1'b0;
    if (!en) begin
      nxt = 0;
    end else begin
      case (m_mode)
        0: if (rise) begin nxt = 1; pul = EvPress; end
        1: begin
          if (fall) begin nxt = 2; pul = EvRel; end
          else if (el == LongClk) begin nxt = 3; pul = EvLong; end
        end
        2: begin
          if (rise) begin nxt = 4; pul = EvPress | EvDclk; end
          else if (el == DoubleClk) begin nxt = 0; pul = EvClick; end
        end
        3: begin
          if (fall) begin nxt = 0; pul = EvRel; end
          else if (el == RepeatClk) begin pul = EvRep; rep = 1'b1; end
        end
        4: if (fall) begin nxt = 0; pul = EvRel; end
        default: nxt = 0;
      endcase
    end
    if (!en || nxt != m_mode || rep) m_mark = cyc;
    m_mode = nxt;
    m_dbq  = db;
    if (!db) m_armed = 1'b1;
    m_exp = ev(pul, 3'(nxt));
  endtask

  // Drive inputs away from the edge, advance one clock, compare against the model on the falling edge.
  task automatic step(input logic db, input logic en);
    i_db = db;
    i_en = en;
    @(posedge i_clk);
    cyc++;
    if (resetn) model_edge(db, en);
    else model_reset();
    @(negedge i_clk);
    check({tag, "/model"}, dut_vec, m_exp);
  endtask

  task automatic add(input string name, input logic db, input int n, input logic [5:0] pul,
                     input logic [2:0] st);
    seg_t s;
    s.name = name; s.db = db; s.en = 1'b1; s.n = n; s.pul = pul; s.st = st;
    tbl.push_back(s);
  endtask

  initial begin
    resetn = 1'b0;
    i_db   = 1'b1;
    i_en   = 1'b1;
    model_reset();
    @(negedge i_clk);

    // Button held through reset must not produce a press until released and pressed again.
    tag = "reset";
    repeat (3) step(1'b1, 1'b1);
    check("reset_state", dut_vec, '0);
    resetn = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    check("no_press_after_reset", dut_vec, ev(EvNone, 3'd0));
    step(1'b0, 1'b1);
    check("no_release_after_reset", dut_vec, ev(EvNone, 3'd0));
    step(1'b1, 1'b1);
    check("press_after_rearm", dut_vec, ev(EvPress, 3'd1));
    repeat (3) step(1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b1);
    check("rearm_settle", dut_vec, ev(EvNone, 3'd0));

    // Offsets in comments are clocks after o_press.
    add("click", 1, 1, EvPress, 1);
    add("click", 1, 7, EvNone, 1);
    add("click", 0, 1, EvRel, 2);            // +8
    add("click", 0, 19, EvNone, 2);
    add("click", 0, 1, EvClick, 0);          // release+20
    add("click", 0, 4, EvNone, 0);
    add("dclick", 1, 1, EvPress, 1);
    add("dclick", 1, 7, EvNone, 1);
    add("dclick", 0, 1, EvRel, 2);
    add("dclick", 0, 5, EvNone, 2);
    add("dclick", 1, 1, EvPress | EvDclk, 4);
    add("dclick", 1, 9, EvNone, 4);
    add("dclick", 0, 1, EvRel, 0);
    add("dclick", 0, 25, EvNone, 0);
    add("long", 1, 1, EvPress, 1);
    add("long", 1, 39, EvNone, 1);
    add("long", 1, 1, EvLong, 3);            // +40
    add("long", 1, 11, EvNone, 3);
    add("long", 1, 1, EvRep, 3);             // +52
    add("long", 1, 11, EvNone, 3);
    add("long", 1, 1, EvRep, 3);             // +64
    add("long", 1, 5, EvNone, 3);
    add("long", 0, 1, EvRel, 0);             // +70
    add("long", 0, 15, EvNone, 0);
    add("edge_vs_long", 1, 1, EvPress, 1);
    add("edge_vs_long", 1, 39, EvNone, 1);
    add("edge_vs_long", 0, 1, EvRel, 2);     // fall at +40 beats long expiry
    add("edge_vs_dbl", 0, 19, EvNone, 2);
    add("edge_vs_dbl", 1, 1, EvPress | EvDclk, 4);  // rise at release+20 beats click
    add("edge_vs_dbl", 1, 3, EvNone, 4);
    add("edge_vs_dbl", 0, 1, EvRel, 0);
    add("edge_vs_dbl", 0, 25, EvNone, 0);

    foreach (tbl[i]) begin
      tag = tbl[i].name;
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].db, tbl[i].en);
      check($sformatf("%s[%0d]", tbl[i].name, i), dut_vec, ev(tbl[i].pul, tbl[i].st));
    end

    // Enable dropped while long-held, then re-enabled with the button still down.
    tag = "en_drop";
    step(1'b1, 1'b1);
    check("en_drop_press", dut_vec, ev(EvPress, 3'd1));
    repeat (44) step(1'b1, 1'b1);
    check("en_drop_in_long", dut_vec, ev(EvNone, 3'd3));
    repeat (3) step(1'b1, 1'b0);
    check("en_low_idle", dut_vec, ev(EvNone, 3'd0));
    repeat (10) step(1'b1, 1'b1);
    check("reenable_held_quiet", dut_vec, ev(EvNone, 3'd0));
    step(1'b0, 1'b1);
    check("reenable_no_release", dut_vec, ev(EvNone, 3'd0));
    repeat (30) step(1'b0, 1'b1);
    check("reenable_no_click", dut_vec, ev(EvNone, 3'd0));

    // Asynchronous reset in the middle of a press.
    tag = "async_reset";
    step(1'b1, 1'b1);
    check("ar_press", dut_vec, ev(EvPress, 3'd1));
    repeat (10) step(1'b1, 1'b1);
    check("ar_down1", dut_vec, ev(EvNone, 3'd1));
    resetn = 1'b0;
    #1;
    check("ar_immediate", dut_vec, '0);
    model_reset();
    repeat (2) step(1'b1, 1'b1);
    resetn = 1'b1;
    repeat (4) step(1'b1, 1'b1);
    check("ar_no_press", dut_vec, ev(EvNone, 3'd0));
    repeat (31) step(1'b0, 1'b1);
    check("ar_quiet", dut_vec, ev(EvNone, 3'd0));

    // Random button activity with occasional disables and resets.
    tag = "random";
    begin
      logic db_cur, en_cur;
      int   len;
      db_cur = 1'b0;
      for (int r = 0; r < 160; r++) begin
        db_cur = ~db_cur;
        en_cur = ($urandom_range(0, 24) != 0);
        len    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(30, 90))
                                             : int'($urandom_range(1, 25));
        if ($urandom_range(0, 39) == 0) begin
          resetn = 1'b0;
          repeat (2) step(db_cur, en_cur);
          resetn = 1'b1;
        end
        for (int k = 0; k < len; k++) step(db_cur, en_cur);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
